// File: rtl/cdc_tx_arbiter_pkg.sv
// cdc_arb_pkg: shared types and constants for the CDC transmit arbiter.
//   cdc_arb_state_t : arbiter FSM states (IDLE, TAG, GRANT)
//   TAG_BASE        : upper nibble of the channel tag byte (tag = TAG_BASE | channel)
//   sat_inc8        : 8-bit saturating increment used by the gap timer
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAG   = 2'd1,
    GRANT = 2'd2
  } cdc_arb_state_t;

  localparam logic [7:0] TAG_BASE = 8'hF0;

  // Increment that sticks at 255 so a long idle run cannot wrap back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

endpackage

// File: rtl/cdc_tx_arbiter_if.sv
// cdc_tx_arbiter_if: byte-stream bundle between NCH requesters, the arbiter
// and the usb_serial_top send port.
//   req_data/req_valid/req_ready : per-channel requester handshake
//   send_data/send_valid/send_ready : shared stream toward usb_serial_top
//   grant_id/busy                : arbiter status
// Modports: slave = arbiter side, master = user logic / sink side.
interface cdc_tx_arbiter_if #(
  parameter int NCH = 4
);
  localparam int IW = $clog2(NCH);

  logic [NCH-1:0][7:0] req_data;
  logic [NCH-1:0]      req_valid;
  logic [NCH-1:0]      req_ready;
  logic [7:0]          send_data;
  logic                send_valid;
  logic                send_ready;
  logic [IW-1:0]       grant_id;
  logic                busy;

  modport slave (
    input  req_data, req_valid, send_ready,
    output req_ready, send_data, send_valid, grant_id, busy
  );

  modport master (
    output req_data, req_valid, send_ready,
    input  req_ready, send_data, send_valid, grant_id, busy
  );

endinterface

// File: rtl/cdc_tx_arbiter_rr_pick.sv
// cdc_rr_pick: combinational round-robin priority encoder.
//   req   : request vector, one bit per channel
//   last  : most recently granted channel; the search starts just after it
//   found : at least one request is pending
//   idx   : first requesting channel after last, wrapping at NCH
module cdc_rr_pick #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  output logic           found,
  output logic [IW-1:0]  idx
);

  int            sum_s;
  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Walk the channels in rotation order from last+1; the first hit wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    sum_s  = 0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      sum_s  = int'(last) + 1 + k;
      // sum_s never exceeds 2*NCH-1, so one conditional subtract wraps it
      cand_s = IW'((sum_s >= NCH) ? (sum_s - NCH) : sum_s);
      hit_s  = req[cand_s] & ~found;
      idx    = hit_s ? cand_s : idx;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: shares the single CDC device-to-host byte stream between NCH
// byte-stream requesters with burst-granular round-robin grants. A grant ends
// after MAXBURST accepted bytes or GAP consecutive idle cycles of the granted
// channel; with TAG_EN=1 every grant starts with a tag byte TAG_BASE | channel.
// Ports:
//   clk      : system clock
//   usb_rstn : asynchronous active-low reset
//   bus      : cdc_tx_arbiter_if.slave (requester handshakes, send stream, status)
module cdc_tx_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int MAXBURST = 32,
  parameter int GAP      = 64,
  parameter int TAG_EN   = 1
) (
  input  logic                 clk,
  input  logic                 usb_rstn,
  cdc_tx_arbiter_if.slave      bus
);

  localparam int             IW         = $clog2(NCH);
  localparam logic [7:0]     MAXBURST_B = 8'(MAXBURST);
  localparam logic [7:0]     GAP_B      = 8'(GAP);

  cdc_arb_state_t state_r;
  logic [IW-1:0]  g_r;
  logic [IW-1:0]  last_r;
  logic [7:0]     burst_r;
  logic [7:0]     gap_r;

  logic           pick_found_s;
  logic [IW-1:0]  pick_idx_s;
  logic           accept_s;
  logic           g_valid_s;
  logic [7:0]     burst_inc_s;
  logic [7:0]     gap_inc_s;
  logic [NCH-1:0] req_ready_s;
  logic [7:0]     send_data_s;
  logic           send_valid_s;

  cdc_rr_pick #(
    .NCH (NCH),
    .IW  (IW)
  ) u_pick (
    .req   (bus.req_valid),
    .last  (last_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Granted-channel handshake and next counter values.
  always_comb begin
    g_valid_s   = bus.req_valid[g_r];
    accept_s    = (state_r == GRANT) && g_valid_s && bus.send_ready;
    burst_inc_s = burst_r + 8'd1;
    gap_inc_s   = sat_inc8(gap_r);
  end

  // Output muxes: quiet in IDLE, tag byte in TAG, transparent pass-through in GRANT.
  always_comb begin
    req_ready_s  = '0;
    send_data_s  = 8'h00;
    send_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        send_valid_s = 1'b0;
      end
      TAG: begin
        send_data_s  = TAG_BASE | 8'(g_r);
        send_valid_s = 1'b1;
      end
      GRANT: begin
        send_data_s        = bus.req_data[g_r];
        send_valid_s       = g_valid_s;
        req_ready_s[g_r]   = bus.send_ready;
      end
      default: begin
        send_valid_s = 1'b0;
      end
    endcase
  end

  // Arbiter FSM with grant/last registers and burst/gap counters.
  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      state_r <= IDLE;
      g_r     <= '0;
      last_r  <= IW'(NCH - 1);   // channel 0 is first in line after reset
      burst_r <= 8'd0;
      gap_r   <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            g_r     <= pick_idx_s;
            last_r  <= pick_idx_s;
            burst_r <= 8'd0;
            gap_r   <= 8'd0;
            state_r <= (TAG_EN != 0) ? TAG : GRANT;
          end
        end
        TAG: begin
          if (bus.send_ready) begin
            state_r <= GRANT;
          end
        end
        GRANT: begin
          if (accept_s) begin
            burst_r <= burst_inc_s;
            gap_r   <= 8'd0;
            if (burst_inc_s == MAXBURST_B) begin
              state_r <= IDLE;
            end
          end else if (!g_valid_s) begin
            gap_r <= gap_inc_s;
            if (gap_inc_s == GAP_B) begin
              state_r <= IDLE;
            end
          end
          // valid with no ready is backpressure: counters hold
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.send_data  = send_data_s;
  assign bus.send_valid = send_valid_s;
  assign bus.grant_id   = g_r;
  assign bus.busy       = (state_r != IDLE);

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// tb_cdc_tx_arbiter: randomized and scenario stimulus for cdc_tx_arbiter,
// checked cycle by cycle against a behavioural model of the grant rules.
module tb_cdc_tx_arbiter;

  localparam int NCH = 4;
  localparam int MB  = 32;
  localparam int GP  = 64;

  logic clk = 1'b0;
  logic usb_rstn;

  always #5 clk = ~clk;

  cdc_tx_arbiter_if #(.NCH(NCH)) bus_a ();
  cdc_tx_arbiter_if #(.NCH(NCH)) bus_b ();

  cdc_tx_arbiter #(.NCH(NCH), .MAXBURST(MB), .GAP(GP), .TAG_EN(1)) dut_a (
    .clk      (clk),
    .usb_rstn (usb_rstn),
    .bus      (bus_a)
  );

  cdc_tx_arbiter #(.NCH(NCH), .MAXBURST(1), .GAP(GP), .TAG_EN(0)) dut_b (
    .clk      (clk),
    .usb_rstn (usb_rstn),
    .bus      (bus_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] src_q[NCH][$];
  bit         en[NCH];
  bit         held[NCH];
  bit         sr;
  logic [7:0] out_log[$];
  int         busy_cnt;
  int         ready_cnt;

  // reference model: which channel holds the stream (-1 = none) and its progress
  int m_ch, m_last, m_gid, m_sent, m_quiet;
  bit m_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] logv(input int i);
    return (out_log.size() > i) ? {24'h0, out_log[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    m_ch = -1; m_last = NCH - 1; m_gid = 0; m_tag = 1'b0; m_sent = 0; m_quiet = 0;
  endtask

  task automatic model_expect(input logic [NCH-1:0] rv, input logic [NCH-1:0][7:0] rd,
                              input bit r, output logic [15:0] e);
    logic       b, v;
    logic [3:0] rr;
    logic [7:0] d;
    b = 1'b0; v = 1'b0; rr = 4'h0; d = 8'h00;
    if (m_ch >= 0) begin
      b = 1'b1;
      if (m_tag) begin
        v = 1'b1; d = 8'hF0 + 8'(m_ch);
      end else begin
        v = rv[m_ch]; d = rd[m_ch]; rr[m_ch] = r;
      end
    end
    e = {b, v, rr, 2'(m_gid), v ? d : 8'h00};
  endtask

  task automatic model_advance(input logic [NCH-1:0] rv, input bit r);
    int c;
    if (m_ch < 0) begin
      for (int k = 1; k <= NCH; k++) begin
        c = (m_last + k) % NCH;
        if (m_ch < 0 && rv[c]) m_ch = c;
      end
      if (m_ch >= 0) begin
        m_last = m_ch; m_gid = m_ch; m_tag = 1'b1; m_sent = 0; m_quiet = 0;
      end
    end else if (m_tag) begin
      if (r) m_tag = 1'b0;
    end else if (rv[m_ch] && r) begin
      m_sent++; m_quiet = 0;
      if (m_sent == MB) m_ch = -1;
    end else if (!rv[m_ch]) begin
      m_quiet++;
      if (m_quiet == GP) m_ch = -1;
    end
  endtask

  // one clock of dut_a: drive, sample at negedge, compare, update sources and model
  task automatic step_a();
    logic [NCH-1:0]      rv;
    logic [NCH-1:0][7:0] rd;
    logic [15:0]         e, o;
    for (int c = 0; c < NCH; c++) begin
      rv[c] = (src_q[c].size() > 0) && (en[c] || held[c]);
      rd[c] = (src_q[c].size() > 0) ? src_q[c][0] : 8'h00;
    end
    bus_a.req_valid  = rv;
    bus_a.req_data   = rd;
    bus_a.send_ready = sr;
    @(negedge clk);
    model_expect(rv, rd, sr, e);
    o = {bus_a.busy, bus_a.send_valid, bus_a.req_ready, bus_a.grant_id,
         bus_a.send_valid ? bus_a.send_data : 8'h00};
    chk("cycle", {16'h0, o}, {16'h0, e});
    if (bus_a.busy) busy_cnt++;
    if (bus_a.req_ready != 4'h0) ready_cnt++;
    if (bus_a.send_valid && sr) out_log.push_back(bus_a.send_data);
    for (int c = 0; c < NCH; c++) begin
      if (rv[c] && bus_a.req_ready[c]) begin
        void'(src_q[c].pop_front());
        held[c] = 1'b0;
      end else begin
        held[c] = rv[c];
      end
    end
    model_advance(rv, sr);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  {31'h0, bus_a.busy},       32'h0);
    chk({tag, "_sv"},    {31'h0, bus_a.send_valid}, 32'h0);
    chk({tag, "_rr"},    {28'h0, bus_a.req_ready},  32'h0);
    chk({tag, "_sd"},    {24'h0, bus_a.send_data},  32'h0);
    chk({tag, "_gid"},   {30'h0, bus_a.grant_id},   32'h0);
  endtask

  task automatic reset_all(input bit check);
    usb_rstn = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      src_q[c].delete(); en[c] = 1'b0; held[c] = 1'b0;
    end
    sr = 1'b1; out_log.delete(); busy_cnt = 0; ready_cnt = 0;
    bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.send_ready = 1'b1;
    bus_b.req_valid = '0; bus_b.req_data = '0; bus_b.send_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (check) chk_reset_vals("reset");
    usb_rstn = 1'b1;
  endtask

  task automatic gap_case(input int gl);
    reset_all(1'b0);
    for (int i = 0; i < 4; i++) src_q[1].push_back(8'h21 + 8'(i));
    en[1] = 1'b1;
    for (int t = 0; t < 20 && src_q[1].size() > 1; t++) step_a();
    en[1] = 1'b0;
    repeat (gl) step_a();
    en[1] = 1'b1;
    repeat (80) step_a();
    chk("gap_n",  out_log.size(), (gl < GP) ? 32'd5 : 32'd6);
    chk("gap_t",  logv(0), 32'hF1);
    chk("gap_d1", logv(1), 32'h21);
    chk("gap_d2", logv(2), 32'h22);
    chk("gap_d3", logv(3), 32'h23);
    if (gl < GP) begin
      chk("gap_d4", logv(4), 32'h24);
    end else begin
      chk("gap_t2", logv(4), 32'hF1);
      chk("gap_d4", logv(5), 32'h24);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_v;
    int          n;
    int          ch;
    usb_rstn = 1'b0;

    // reset state
    reset_all(1'b1);

    // MAXBURST=1, no tag: ch0 byte, idle, ch1 byte, idle, ...
    bus_b.req_valid = 4'b0011;
    bus_b.req_data  = {8'h00, 8'h00, 8'hB1, 8'hA0};
    bus_b.send_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i % 2 == 0) exp_v = 32'h0;
      else if (((i / 2) % 2) == 0) exp_v = {19'h0, 1'b1, 8'hA0, 4'b0001};
      else exp_v = {19'h0, 1'b1, 8'hB1, 4'b0010};
      chk("alt", {19'h0, bus_b.send_valid, bus_b.send_valid ? bus_b.send_data : 8'h00,
                  bus_b.req_ready}, exp_v);
      @(posedge clk);
      #1;
    end
    bus_b.req_valid = 4'b0000;

    // single channel 2: tag F2 then 11..15, busy drops after 64 idle cycles
    reset_all(1'b0);
    for (int i = 0; i < 5; i++) src_q[2].push_back(8'h11 + 8'(i));
    en[2] = 1'b1;
    repeat (80) step_a();
    chk("s1_n", out_log.size(), 32'd6);
    chk("s1_t", logv(0), 32'hF2);
    for (int i = 0; i < 5; i++) chk("s1_d", logv(i + 1), 32'h11 + i);
    chk("s1_busy", busy_cnt, 32'd70);

    // all channels saturated: bursts 0,1,2,3,0 of 32 bytes, one idle between
    reset_all(1'b0);
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < 64; i++) src_q[c].push_back(8'(c * 64 + i));
      en[c] = 1'b1;
    end
    repeat (5 * (MB + 2)) step_a();
    chk("s2_n", out_log.size(), 32'd165);
    chk("s2_idle", 5 * (MB + 2) - busy_cnt, 32'd5);
    for (int k = 0; k < 5; k++) begin
      ch = k % NCH;
      chk("s2_tag", logv(k * (MB + 1)), 32'hF0 + ch);
      for (int j = 0; j < MB; j++)
        chk("s2_dat", logv(k * (MB + 1) + 1 + j), (ch * 64 + (k / NCH) * MB + j) % 256);
    end

    // gap of 63 keeps the grant, gap of 64 releases it
    gap_case(GP - 1);
    gap_case(GP);

    // long send_ready stall mid-burst
    reset_all(1'b0);
    for (int i = 0; i < 10; i++) src_q[0].push_back(8'h50 + 8'(i));
    en[0] = 1'b1;
    for (int t = 0; t < 20 && src_q[0].size() > 6; t++) step_a();
    sr = 1'b0; ready_cnt = 0; busy_cnt = 0;
    repeat (500) step_a();
    chk("s4_rdy", ready_cnt, 32'd0);
    chk("s4_busy", busy_cnt, 32'd500);
    sr = 1'b1;
    repeat (80) step_a();
    chk("s4_n", out_log.size(), 32'd11);
    chk("s4_t", logv(0), 32'hF0);
    for (int i = 0; i < 10; i++) chk("s4_d", logv(i + 1), 32'h50 + i);

    // asynchronous reset during ch3 grant, then ch2 wins over ch3
    reset_all(1'b0);
    for (int i = 0; i < 10; i++) src_q[3].push_back(8'h60 + 8'(i));
    en[3] = 1'b1;
    for (int t = 0; t < 20 && src_q[3].size() > 7; t++) step_a();
    chk("s5_pre_gid", {30'h0, bus_a.grant_id}, 32'd3);
    usb_rstn = 1'b0;
    #1;
    chk_reset_vals("async");
    reset_all(1'b0);
    src_q[2].push_back(8'h31); src_q[2].push_back(8'h32);
    src_q[3].push_back(8'h41); src_q[3].push_back(8'h42);
    en[2] = 1'b1; en[3] = 1'b1;
    repeat (6) step_a();
    chk("s5_t", logv(0), 32'hF2);
    chk("s5_d", logv(1), 32'h31);

    // randomized traffic with backpressure and idle runs
    reset_all(1'b0);
    for (int c = 0; c < NCH; c++) begin
      n = $urandom_range(80, 0);
      for (int i = 0; i < n; i++) src_q[c].push_back(8'($urandom));
      en[c] = 1'($urandom_range(1, 0));
    end
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(99, 0) < 3) en[c] = !en[c];
      if ($urandom_range(199, 0) == 0) begin
        ch = $urandom_range(NCH - 1, 0);
        for (int i = 0; i < 20; i++) src_q[ch].push_back(8'($urandom));
      end
      sr = ($urandom_range(9, 0) < 8);
      step_a();
    end
    sr = 1'b1;
    for (int c = 0; c < NCH; c++) en[c] = 1'b1;
    for (int t = 0; t < 3000 && (src_q[0].size() + src_q[1].size() +
                                 src_q[2].size() + src_q[3].size()) > 0; t++) step_a();
    for (int c = 0; c < NCH; c++) chk("drain", src_q[c].size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
